// File: rtl/com_uart_rcv.sv
// UART receiver: oversampled frame recovery (start, 5-8 data, opt. parity, 1-2 stop) with error flags.
// Latency: data_valid rises 1 clk after the mid-bit sample of the last stop bit (synchronizer adds SYNC_STAGES clks).
// Backpressure: none; data_valid is a one-clk strobe, data_out/flags hold until the next frame completes.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   tick_os             one-clk enable at OVERSAMPLE x baud
//   rx_port             asynchronous serial line
//   stop_bit_config     0 = one stop bit, 1 = two
//   parity_bit_config   [1] parity enable, [0] 1 odd / 0 even
//   data_bit_config     data bits = value + 5
//   data_out            received byte, LSB-aligned, unused upper bits zero
//   data_valid          one-clk frame-complete strobe
//   parity_err          parity mismatch for the frame in data_out
//   frame_err           bad stop-bit level for the frame in data_out
//   ctrl_idle_state     high while in IDLE
// Optional macro COM_UART_RCV_MAJORITY_EN: each bit is the 2-of-3 majority of three
// consecutive tick samples centred on the single-sample point.
module com_uart_rcv #(
  parameter int   OVERSAMPLE  = 16,
  parameter logic START_BIT   = 1'b0,
  parameter logic STOP_BIT    = 1'b1,
  parameter int   SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_os,
  input  logic       rx_port,
  input  logic       stop_bit_config,
  input  logic [1:0] parity_bit_config,
  input  logic [1:0] data_bit_config,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       ctrl_idle_state
);

  localparam int TW = $clog2(OVERSAMPLE);
`ifdef COM_UART_RCV_MAJORITY_EN
  // Decide one tick later so the three samples straddle the single-sample point.
  localparam int START_PT = OVERSAMPLE / 2;
`else
  localparam int START_PT = OVERSAMPLE / 2 - 1;
`endif
  localparam logic [TW-1:0] START_PT_C = TW'(START_PT);
  localparam logic [TW-1:0] LAST_C     = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_STOP2, S_DONE, S_BREAK
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              perr_q, perr_d, ferr_q, ferr_d;
  logic              cfg_stop_q, cfg_stop_d;
  logic [1:0]        cfg_par_q, cfg_par_d;
  logic [1:0]        cfg_dbits_q, cfg_dbits_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic              rx_s, rx_bit, samp_now, load_out, par_exp;
  logic [7:0]        data_mask, data_m;

  // Input synchronizer, free-running on clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{STOP_BIT}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx_port};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef COM_UART_RCV_MAJORITY_EN
  logic [1:0] hist_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       hist_q <= {2{STOP_BIT}};
    else if (tick_os) hist_q <= {hist_q[0], rx_s};
  end
  assign rx_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign rx_bit = rx_s;
`endif

  // Only the N received bits take part in parity and appear on data_out.
  assign data_mask = 8'hFF >> (3'd3 - {1'b0, cfg_dbits_q});
  assign data_m    = shift_q & data_mask;
  assign par_exp   = cfg_par_q[0] ? ~^data_m : ^data_m;

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    cfg_stop_d  = cfg_stop_q;
    cfg_par_d   = cfg_par_q;
    cfg_dbits_d = cfg_dbits_q;
    // START samples at the half-bit point; afterwards every OVERSAMPLE ticks.
    if (state_q == S_START) samp_now = tick_os && (tick_cnt_q == START_PT_C);
    else                    samp_now = tick_os && (tick_cnt_q == LAST_C);
    if (tick_os) tick_cnt_d = samp_now ? '0 : tick_cnt_q + TW'(1);

    case (state_q)
      S_IDLE: begin
        tick_cnt_d = '0;
        if (tick_os && rx_s == START_BIT) begin
          state_d     = S_START;
          cfg_stop_d  = stop_bit_config;
          cfg_par_d   = parity_bit_config;
          cfg_dbits_d = data_bit_config;
          perr_d      = 1'b0;
          ferr_d      = 1'b0;
          shift_d     = '0;
        end
      end
      S_START: begin
        if (samp_now) begin
          if (rx_bit != START_BIT) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
      end
      S_DATA: begin
        if (samp_now) begin
          shift_d[bit_cnt_q] = rx_bit;
          if (bit_cnt_q == {1'b0, cfg_dbits_q} + 3'd4) begin
            state_d = cfg_par_q[1] ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (samp_now) begin
          if (rx_bit != par_exp) perr_d = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (samp_now) begin
          if (rx_bit != STOP_BIT) ferr_d = 1'b1;
          state_d = cfg_stop_q ? S_STOP2 : S_DONE;
        end
      end
      S_STOP2: begin
        if (samp_now) begin
          if (rx_bit != STOP_BIT) ferr_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        tick_cnt_d = '0;
        // A held-low line after a framing error must not look like a new start.
        state_d    = ferr_q ? S_BREAK : S_IDLE;
      end
      S_BREAK: begin
        tick_cnt_d = '0;
        if (tick_os && rx_s == STOP_BIT) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs load on the edge that enters DONE so they are valid during the strobe.
  assign load_out = (state_d == S_DONE) && (state_q != S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      cfg_stop_q  <= 1'b0;
      cfg_par_q   <= '0;
      cfg_dbits_q <= '0;
      data_out    <= '0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      cfg_stop_q  <= cfg_stop_d;
      cfg_par_q   <= cfg_par_d;
      cfg_dbits_q <= cfg_dbits_d;
      if (load_out) begin
        data_out   <= shift_d & data_mask;
        parity_err <= perr_d;
        frame_err  <= ferr_d;
      end
    end
  end

  assign data_valid      = (state_q == S_DONE);
  assign ctrl_idle_state = (state_q == S_IDLE);

endmodule

// File: tb/tb_com_uart_rcv.sv
module tb_com_uart_rcv;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_os = 1'b0;
  logic       rx_port = 1'b1;
  logic       stop_bit_config = 1'b0;
  logic [1:0] parity_bit_config = 2'b00;
  logic [1:0] data_bit_config = 2'b00;
  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err, ctrl_idle_state;

  int n_chk = 0;
  int n_pass = 0;
  int dv_cnt = 0;
  int tdiv = 0;
  logic [7:0] cap_data = 8'h00;
  logic cap_perr = 1'b0, cap_ferr = 1'b0;

  com_uart_rcv #(.OVERSAMPLE(OS)) dut (
    .clk(clk), .rst_n(rst_n), .tick_os(tick_os), .rx_port(rx_port),
    .stop_bit_config(stop_bit_config), .parity_bit_config(parity_bit_config),
    .data_bit_config(data_bit_config), .data_out(data_out), .data_valid(data_valid),
    .parity_err(parity_err), .frame_err(frame_err), .ctrl_idle_state(ctrl_idle_state)
  );

  always #5 clk = ~clk;

  // One tick every 4 clks, changed on the falling edge.
  always @(negedge clk) begin
    tdiv = (tdiv + 1) % 4;
    tick_os = (tdiv == 0);
  end

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt++;
      cap_data = data_out;
      cap_perr = parity_err;
      cap_ferr = frame_err;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  // Drive one oversample slot: the value is seen by the DUT at the next tick.
  task automatic slot(input logic v);
    rx_port = v;
    do @(posedge clk); while (!tick_os);
    #1;
  endtask

  task automatic idle_slots(input int n);
    for (int i = 0; i < n; i++) slot(1'b1);
  endtask

  // Transmit one frame as the transmitter would; glitch inverts one slot,
  // rst_at pulses reset at that slot and abandons the frame.
  task automatic send_frame(input logic [1:0] db, input logic [1:0] par, input logic st,
                            input logic [7:0] d, input logic pflip, input logic [1:0] sbad,
                            input int glitch, input int rst_at);
    logic bits[$];
    logic v;
    logic [7:0] dm;
    int n;
    stop_bit_config = st;
    parity_bit_config = par;
    data_bit_config = db;
    n = int'(db) + 5;
    dm = d & (8'hFF >> (8 - n));
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) bits.push_back(d[i]);
    if (par[1]) bits.push_back((par[0] ? ~^dm : ^dm) ^ pflip);
    bits.push_back(~sbad[0]);
    if (st) bits.push_back(~sbad[1]);
    for (int b = 0; b < bits.size(); b++) begin
      for (int s = 0; s < OS; s++) begin
        int j;
        j = b * OS + s;
        v = bits[b];
        if (j == glitch) v = ~v;
        if (j == rst_at) begin
          rst_n = 1'b0;
          rx_port = 1'b1;
          #3;
          chk("rst_mid_data_out", int'(data_out), 0);
          chk("rst_mid_valid", int'(data_valid), 0);
          chk("rst_mid_perr", int'(parity_err), 0);
          chk("rst_mid_ferr", int'(frame_err), 0);
          chk("rst_mid_idle", int'(ctrl_idle_state), 1);
          rst_n = 1'b1;
          return;
        end
        // Config is latched at start detection; scramble it mid-frame.
        if (b == 1 && s == 0) begin
          stop_bit_config = 1'($urandom);
          parity_bit_config = 2'($urandom);
          data_bit_config = 2'($urandom);
        end
        slot(v);
      end
    end
  endtask

  task automatic expect_frame(input string nm, input int dv0, input logic [7:0] ed,
                              input logic ep, input logic ef);
    chk({nm, "_valid_once"}, dv_cnt - dv0, 1);
    chk({nm, "_data"}, int'(cap_data), int'(ed));
    chk({nm, "_perr"}, int'(cap_perr), int'(ep));
    chk({nm, "_ferr"}, int'(cap_ferr), int'(ef));
  endtask

  typedef struct {
    logic [1:0] db;
    logic [1:0] par;
    logic       st;
    logic [7:0] d;
    logic       pflip;
    logic [1:0] sbad;
    logic [7:0] e_data;
    logic       e_perr;
    logic       e_ferr;
  } vec_t;

  initial begin
    vec_t vt[6];
    int dv0;
    logic [7:0] exp_glitch;

    vt[0] = '{2'd3, 2'b00, 1'b0, 8'hA5, 1'b0, 2'b00, 8'hA5, 1'b0, 1'b0}; // 8N1
    vt[1] = '{2'd2, 2'b11, 1'b1, 8'h41, 1'b0, 2'b00, 8'h41, 1'b0, 1'b0}; // 7O2
    vt[2] = '{2'd2, 2'b11, 1'b1, 8'h41, 1'b1, 2'b00, 8'h41, 1'b1, 1'b0}; // 7O2 bad parity
    vt[3] = '{2'd3, 2'b10, 1'b0, 8'h3C, 1'b0, 2'b00, 8'h3C, 1'b0, 1'b0}; // 8E1
    vt[4] = '{2'd1, 2'b10, 1'b1, 8'hFF, 1'b0, 2'b00, 8'h3F, 1'b0, 1'b0}; // 6E2, upper bits zero
    vt[5] = '{2'd0, 2'b00, 1'b1, 8'h15, 1'b0, 2'b10, 8'h15, 1'b0, 1'b1}; // 5N2 second stop low

    repeat (5) @(posedge clk);
    #1;
    chk("reset_data_out", int'(data_out), 0);
    chk("reset_valid", int'(data_valid), 0);
    chk("reset_perr", int'(parity_err), 0);
    chk("reset_ferr", int'(frame_err), 0);
    chk("reset_idle", int'(ctrl_idle_state), 1);
    rst_n = 1'b1;
    idle_slots(20);

    for (int i = 0; i < 6; i++) begin
      dv0 = dv_cnt;
      send_frame(vt[i].db, vt[i].par, vt[i].st, vt[i].d, vt[i].pflip, vt[i].sbad, -1, -1);
      expect_frame($sformatf("vec%0d", i), dv0, vt[i].e_data, vt[i].e_perr, vt[i].e_ferr);
      idle_slots(20);
    end

    // Framing error followed by a held-low break, then a clean frame.
    dv0 = dv_cnt;
    send_frame(2'd0, 2'b00, 1'b0, 8'h1F, 1'b0, 2'b01, -1, -1);
    expect_frame("brk_first", dv0, 8'h1F, 1'b0, 1'b1);
    for (int i = 0; i < 3 * OS; i++) slot(1'b0);
    chk("brk_no_retrigger", dv_cnt - dv0, 1);
    idle_slots(OS);
    dv0 = dv_cnt;
    send_frame(2'd0, 2'b00, 1'b0, 8'h03, 1'b0, 2'b00, -1, -1);
    expect_frame("brk_after", dv0, 8'h03, 1'b0, 1'b0);
    idle_slots(20);

    // Short low glitch on an idle line is a false start.
    dv0 = dv_cnt;
    for (int i = 0; i < 4; i++) slot(1'b0);
    idle_slots(2 * OS);
    chk("glitch_no_valid", dv_cnt - dv0, 0);
    chk("glitch_idle", int'(ctrl_idle_state), 1);

    // Reset during data bit 3 of 0x55, then a full frame.
    dv0 = dv_cnt;
    send_frame(2'd3, 2'b00, 1'b0, 8'h55, 1'b0, 2'b00, -1, OS * 4 + 4);
    idle_slots(2 * OS);
    chk("rst_no_valid", dv_cnt - dv0, 0);
    chk("rst_idle_after", int'(ctrl_idle_state), 1);
    dv0 = dv_cnt;
    send_frame(2'd3, 2'b00, 1'b0, 8'h55, 1'b0, 2'b00, -1, -1);
    expect_frame("rst_next", dv0, 8'h55, 1'b0, 1'b0);
    idle_slots(20);

    // One-tick inversion at the centre of data bit 0.
`ifdef COM_UART_RCV_MAJORITY_EN
    exp_glitch = 8'h00;
`else
    exp_glitch = 8'h01;
`endif
    dv0 = dv_cnt;
    send_frame(2'd3, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, OS + OS / 2, -1);
    expect_frame("bit_glitch", dv0, exp_glitch, 1'b0, 1'b0);
    idle_slots(20);

    // Random frames against the frame-level model.
    for (int k = 0; k < 30; k++) begin
      logic [1:0] db, par, sbad;
      logic st, pflip;
      logic [7:0] d, e_data;
      int n;
      db = 2'($urandom);
      par = 2'($urandom);
      st = 1'($urandom);
      d = 8'($urandom);
      pflip = par[1] & 1'($urandom);
      sbad = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      n = int'(db) + 5;
      e_data = d & (8'hFF >> (8 - n));
      dv0 = dv_cnt;
      send_frame(db, par, st, d, pflip, sbad, -1, -1);
      expect_frame($sformatf("rnd%0d", k), dv0, e_data, pflip,
                   sbad[0] | (st & sbad[1]));
      idle_slots($urandom_range(1, 8));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
